// File: rtl/dmem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// y86_mem_pkg
// Shared types for the data-memory access controller.
//   MEM_WORDS_DEF : default RAM depth in 64-bit words
//   stat_t        : Y86 status codes (SADR reported as p_err/d_err)
//   state_t       : access sequencer states
//   owner_t       : which requester owns the current access
//   addr_ok()     : full-width unsigned bound check
// ---------------------------------------------------------------------------
package y86_mem_pkg;

    localparam int MEM_WORDS_DEF = 8192;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SADR = 3'd2,
        SINS = 3'd3,
        SHLT = 3'd4
    } stat_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        ERR
    } state_t;

    typedef enum logic {
        PIPE   = 1'b0,
        LOADER = 1'b1
    } owner_t;

    // Compare all 64 bits so that large addresses never alias into the RAM.
    function automatic logic addr_ok(input logic [63:0] addr, input int words);
        return addr < 64'(words);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
// Bundles the two requester ports (pipeline p_*, loader d_*), the RAM port
// (mem_*) and the status outputs of the data-memory access controller.
//   master : requester/RAM side (drives requests and mem_rdata)
//   slave  : controller side (drives ready/rdata/err, RAM strobes, busy)
// Parameter AW : RAM word-address width.
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if #(parameter int AW = 13);

    logic          p_req;
    logic          p_we;
    logic [63:0]   p_addr;
    logic [63:0]   p_wdata;
    logic          p_ready;
    logic [63:0]   p_rdata;
    logic          p_err;
    logic          p_stall;

    logic          d_req;
    logic          d_we;
    logic [63:0]   d_addr;
    logic [63:0]   d_wdata;
    logic          d_ready;
    logic [63:0]   d_rdata;
    logic          d_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata;

    logic          busy;

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  p_ready, p_rdata, p_err, p_stall,
        input  d_ready, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output p_ready, p_rdata, p_err, p_stall,
        output d_ready, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

endinterface

// File: rtl/dmem_access_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_rr_arbiter
// Two-way round-robin arbiter, purely combinational.
//   req[0]=pipeline, req[1]=loader
//   last_grant : owner granted most recently (register lives in the top)
//   gnt        : one-hot grant, all-zero when nothing requests
// ---------------------------------------------------------------------------
module dmem_rr_arbiter
    import y86_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the side that was not served last wins.
        if (&req) begin
            gnt = (last_grant == PIPE) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Sequences accesses to the single-port synchronous data RAM and shares it
// between the pipeline memory stage and the loader/debug port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_access_ctrl_if.slave (p_*, d_*, mem_*, busy)
// Parameters:
//   MEM_WORDS    : RAM depth; addresses >= MEM_WORDS return an error
//   READ_LATENCY : cycles from mem_en to valid mem_rdata (1..7)
// Latency from the IDLE cycle that samples the request: error 1, write 2,
// read 2+READ_LATENCY. All outputs except p_stall/busy are registered.
// ---------------------------------------------------------------------------
module dmem_access_ctrl
    import y86_mem_pkg::*;
#(
    parameter int MEM_WORDS    = MEM_WORDS_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_access_ctrl_if.slave  bus
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(READ_LATENCY + 1);

    state_t          state, state_nxt;
    owner_t          owner_q, owner_nxt, last_grant;
    logic            we_q;
    logic [CW-1:0]   cnt;

    logic [1:0]      gnt;
    logic            sel_we;
    logic [63:0]     sel_addr;
    logic [63:0]     sel_wdata;

    logic            ready_d, err_d;
    logic [63:0]     rdata_d;
    logic            mem_en_d, mem_we_d;
    logic [AW-1:0]   mem_addr_d;
    logic [63:0]     mem_wdata_d;

    dmem_rr_arbiter u_arb (
        .req        ({bus.d_req, bus.p_req}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // Request fields of whichever side the arbiter picked.
    always_comb begin
        if (gnt[1]) begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end else begin
            sel_we    = bus.p_we;
            sel_addr  = bus.p_addr;
            sel_wdata = bus.p_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        unique case (state)
            IDLE: begin
                if (|gnt) begin
                    owner_nxt = gnt[1] ? LOADER : PIPE;
                    state_nxt = addr_ok(sel_addr, MEM_WORDS) ? ACCESS : ERR;
                end
            end
            ACCESS:  state_nxt = we_q ? RESP : WAIT;
            // The counter holds READ_LATENCY-1 on entry, so WAIT spans
            // READ_LATENCY cycles and data is sampled in its last one.
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the
    // upcoming state so each pulse lands in the cycle of that state.
    always_comb begin
        mem_en_d    = (state_nxt == ACCESS);
        mem_we_d    = mem_en_d & sel_we;
        mem_addr_d  = mem_en_d ? sel_addr[AW-1:0] : '0;
        mem_wdata_d = mem_en_d ? sel_wdata : '0;
        ready_d     = (state_nxt == RESP) || (state_nxt == ERR);
        err_d       = (state_nxt == ERR);
        rdata_d     = (state == WAIT && state_nxt == RESP) ? bus.mem_rdata : '0;
    end

    // Request latches, arbitration history and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= PIPE;
            we_q       <= 1'b0;
            last_grant <= LOADER;
            cnt        <= '0;
        end else begin
            if (state == IDLE && |gnt) begin
                owner_q    <= owner_nxt;
                we_q       <= sel_we;
                last_grant <= owner_nxt;
            end
            if (state == ACCESS) begin
                cnt <= CW'(READ_LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Registered outputs; the non-owner side always sees zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.p_ready   <= 1'b0;
            bus.p_err     <= 1'b0;
            bus.p_rdata   <= '0;
            bus.d_ready   <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.p_ready   <= ready_d && (owner_nxt == PIPE);
            bus.p_err     <= err_d   && (owner_nxt == PIPE);
            bus.p_rdata   <= (owner_nxt == PIPE)   ? rdata_d : '0;
            bus.d_ready   <= ready_d && (owner_nxt == LOADER);
            bus.d_err     <= err_d   && (owner_nxt == LOADER);
            bus.d_rdata   <= (owner_nxt == LOADER) ? rdata_d : '0;
            bus.mem_en    <= mem_en_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
        end
    end

    assign bus.p_stall = bus.p_req & ~bus.p_ready;
    assign bus.busy    = (state != IDLE);

endmodule
